ripple_mod: RTL and testbench
=============================

Name: ripple_mod

Overview:
- Parameterised ripple-carry adder built from a chain of 1-bit full-adder cells; carry propagates LSB to MSB.
- Sum and carry-out are registered on the clock, giving a one-cycle-latency arithmetic datapath element.
- Used as a generic adder inside datapaths and as the reference adder for coverage and debug flows.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal values are 1 and above.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands a/b/cin are valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in to bit 0
- out_valid  output  1  sum/cout hold the result of the operands accepted on the previous cycle
- sum  output  WIDTH  registered sum bits [WIDTH-1:0]
- cout  output  1  registered carry-out of the MSB cell

Behaviour:
- Structure: WIDTH full-adder cells, generated in a loop.
  - Cell i computes s[i] = a[i]^b[i]^c[i] and c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]).
  - c[0] = cin; cout_next = c[WIDTH].
- Arithmetic: {cout_next, sum_next} = a + b + cin, computed at WIDTH+1 bits; unsigned, no saturation.
- Wrap-around: a result of 2^WIDTH or more wraps mod 2^WIDTH in sum, with cout=1.
  - Example at WIDTH=8: 0xFF+0xFF+1 gives sum=0xFF, cout=1.
- Reset: on a rising clk with rst=1, sum=0, cout=0 and out_valid=0. Reset overrides in_valid in the same cycle.
- Capture rule: on a rising clk with rst=0 and in_valid=1, sum<=sum_next, cout<=cout_next and out_valid<=1.
- Hold rule: on a rising clk with rst=0 and in_valid=0, sum and cout hold their previous values and out_valid<=0.
- Latency: exactly 1 cycle from operand capture to result.
- Throughput: one operation per cycle. Back-to-back in_valid pulses produce back-to-back out_valid pulses.
- Back-pressure: none; the result is overwritten by the next valid input.
- Reset mid-stream: any in-flight result is discarded. out_valid is 0 on the cycle after reset, and the first valid result follows the first in_valid sampled after rst is released.
- No combinational path from inputs to outputs.
- X on inputs while in_valid=0 must not corrupt the held outputs.

Optional Feature:
- Macro: RIPPLE_MOD_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), registered alongside sum.
  - ovf = c[WIDTH] ^ c[WIDTH-1], the two's-complement signed overflow.
  - ovf resets to 0 and holds when in_valid=0.
- When undefined:
  - Port ovf does not exist.
  - No overflow logic is synthesised.
  - Behaviour is otherwise identical.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and a=0x55, b=0x55 -> sum=0x00, cout=0, out_valid=0. Deassert rst and apply in_valid=1 for one cycle -> out_valid=1 one cycle later.
- Basic adds (WIDTH=8, in_valid=1, one per cycle), each result one cycle later:
  - 0x01+0x01+0 -> sum=0x02, cout=0
  - 0x01+0x01+1 -> 0x03, cout=0
  - 0x02+0x03+0 -> 0x05, cout=0
  - 0x19+0x31+0 -> 0x4A, cout=0
  - 0x03+0x03+1 -> 0x07, cout=0
- Carry out and wrap:
  - 0x81+0x81+0 -> sum=0x02, cout=1
  - 0xFF+0x01+0 -> 0x00, cout=1
  - 0xFF+0x00+1 -> 0x00, cout=1
  - 0xFF+0xFF+0 -> 0xFE, cout=1
- Hold: after 0x19+0x31, drop in_valid and drive a/b to X for 3 cycles -> sum stays 0x4A, cout stays 0, out_valid=0.
- Mid-stream reset: issue valid 0xFF+0x01, then assert rst on the next cycle -> sum=0x00, cout=0, out_valid=0 after that edge; the 0xFF+0x01 result is not presented once reset is sampled.
- With RIPPLE_MOD_OVF_EN:
  - 0x7F+0x01+0 -> sum=0x80, cout=0, ovf=1
  - 0x81+0x81+0 -> sum=0x02, cout=1, ovf=1
  - 0xFF+0x01+0 -> ovf=0
- Randomised check: 1000 random a, b and cin values against the reference model a+b+cin, also at WIDTH=1 and WIDTH=16.

Source files
------------

// File: rtl/ripple_mod.sv
// Registered ripple-carry adder: WIDTH full-adder cells, result one cycle after capture.
// Optional signed-overflow output ovf is enabled by defining RIPPLE_MOD_OVF_EN.
module ripple_mod #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RIPPLE_MOD_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_next_s;

  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             cout_d,      cout_q;
  logic             out_valid_d, out_valid_q;

  assign carry_s[0] = cin;

  // Carry ripples LSB to MSB through one full-adder cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_next_s[i] = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1]  = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
  end

`ifdef RIPPLE_MOD_OVF_EN
  logic ovf_d, ovf_q;
`endif

  // Capture on in_valid, otherwise hold sum/cout; operands are ignored when not valid.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
`ifdef RIPPLE_MOD_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (in_valid) begin
      sum_d       = sum_next_s;
      cout_d      = carry_s[WIDTH];
      out_valid_d = 1'b1;
`ifdef RIPPLE_MOD_OVF_EN
      ovf_d       = carry_s[WIDTH] ^ carry_s[WIDTH-1];
`endif
    end else begin
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = 1'b0;
`ifdef RIPPLE_MOD_OVF_EN
      ovf_d       = ovf_q;
`endif
    end
  end

  // Result registers; reset wins over a simultaneous in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef RIPPLE_MOD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef RIPPLE_MOD_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
`ifdef RIPPLE_MOD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_mod.sv
// Randomised and directed bench for ripple_mod at WIDTH 8, 1 and 16 against an arithmetic model.
// Define RIPPLE_MOD_OVF_EN to also check the signed-overflow output.
module tb_ripple_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, cin;
  logic [7:0]  a8,  b8,  sum8;
  logic [0:0]  a1,  b1,  sum1;
  logic [15:0] a16, b16, sum16;
  logic        cout8, cout1, cout16;
  logic        vld8,  vld1,  vld16;
  logic        ovf8,  ovf1,  ovf16;

  ripple_mod #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .cin(cin),
    .out_valid(vld8), .sum(sum8), .cout(cout8)
`ifdef RIPPLE_MOD_OVF_EN
    , .ovf(ovf8)
`endif
  );

  ripple_mod #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin),
    .out_valid(vld1), .sum(sum1), .cout(cout1)
`ifdef RIPPLE_MOD_OVF_EN
    , .ovf(ovf1)
`endif
  );

  ripple_mod #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a16), .b(b16), .cin(cin),
    .out_valid(vld16), .sum(sum16), .cout(cout16)
`ifdef RIPPLE_MOD_OVF_EN
    , .ovf(ovf16)
`endif
  );

`ifndef RIPPLE_MOD_OVF_EN
  assign ovf8  = 1'b0;
  assign ovf1  = 1'b0;
  assign ovf16 = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int     wid [3] = '{8, 1, 16};
  longint m_sum [3];
  longint m_cout[3];
  longint m_ovf [3];
  bit     m_valid;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signed overflow: the sum of the signed operand values plus cin leaves the W-bit range.
  function automatic longint ref_ovf(input int w, input longint ua, input longint ub, input longint c);
    longint half, sa, sb, s;
    half = longint'(1) << (w - 1);
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    s  = sa + sb + c;
    return ((s > half - 1) || (s < -half)) ? 64'd1 : 64'd0;
  endfunction

  task automatic rand_aux();
    a1  = 1'($urandom);
    b1  = 1'($urandom);
    a16 = 16'($urandom);
    b16 = 16'($urandom);
  endtask

  // Update the model from the inputs presented at this edge, clock once, compare all DUTs.
  task automatic tick();
    longint av[3], bv[3], gs[3], gc[3], gv[3], go[3], mask, r;
    av = '{longint'(a8), longint'(a1), longint'(a16)};
    bv = '{longint'(b8), longint'(b1), longint'(b16)};
    if (rst) begin
      m_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_sum[k] = 0; m_cout[k] = 0; m_ovf[k] = 0;
      end
    end else if (in_valid) begin
      m_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        mask = (longint'(1) << wid[k]) - 1;
        r = (av[k] & mask) + (bv[k] & mask) + longint'(cin);
        m_sum[k]  = r & mask;
        m_cout[k] = r >> wid[k];
        m_ovf[k]  = ref_ovf(wid[k], av[k] & mask, bv[k] & mask, longint'(cin));
      end
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    gs = '{longint'(sum8),  longint'(sum1),  longint'(sum16)};
    gc = '{longint'(cout8), longint'(cout1), longint'(cout16)};
    gv = '{longint'(vld8),  longint'(vld1),  longint'(vld16)};
    go = '{longint'(ovf8),  longint'(ovf1),  longint'(ovf16)};
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("w%0d_sum", wid[k]), gs[k], m_sum[k]);
      check_eq($sformatf("w%0d_cout", wid[k]), gc[k], m_cout[k]);
      check_eq($sformatf("w%0d_out_valid", wid[k]), gv[k], longint'(m_valid));
`ifdef RIPPLE_MOD_OVF_EN
      check_eq($sformatf("w%0d_ovf", wid[k]), go[k], m_ovf[k]);
`endif
    end
  endtask

  task automatic add8(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic [7:0] e_sum, input logic e_cout, input string tag);
    in_valid = 1'b1; a8 = x; b8 = y; cin = c;
    rand_aux();
    tick();
    check_eq({tag, "_sum"}, longint'(sum8), longint'(e_sum));
    check_eq({tag, "_cout"}, longint'(cout8), longint'(e_cout));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a8 = 8'h55; b8 = 8'h55; cin = 1'b0;
    rand_aux();
    tick();
    tick();
    check_eq("rst_sum", longint'(sum8), 64'h0);
    check_eq("rst_cout", longint'(cout8), 64'h0);
    check_eq("rst_out_valid", longint'(vld8), 64'h0);
    rst = 1'b0;
    tick();
    check_eq("first_out_valid", longint'(vld8), 64'h1);
    check_eq("first_sum", longint'(sum8), 64'hAA);

    add8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "add_1_1");
    add8(8'h01, 8'h01, 1'b1, 8'h03, 1'b0, "add_1_1_c");
    add8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, "add_2_3");
    add8(8'h03, 8'h03, 1'b1, 8'h07, 1'b0, "add_3_3_c");
    add8(8'h81, 8'h81, 1'b0, 8'h02, 1'b1, "wrap_81_81");
    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap_ff_01");
    add8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "wrap_ff_00_c");
    add8(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, "wrap_ff_ff");
    add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "wrap_ff_ff_c");
`ifdef RIPPLE_MOD_OVF_EN
    add8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "ovf_7f_01");
    check_eq("ovf_7f_01_ovf", longint'(ovf8), 64'h1);
    add8(8'h81, 8'h81, 1'b0, 8'h02, 1'b1, "ovf_81_81");
    check_eq("ovf_81_81_ovf", longint'(ovf8), 64'h1);
    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf_ff_01");
    check_eq("ovf_ff_01_ovf", longint'(ovf8), 64'h0);
`endif

    add8(8'h19, 8'h31, 1'b0, 8'h4A, 1'b0, "add_19_31");
    in_valid = 1'b0; a8 = 'x; b8 = 'x; a1 = 'x; b1 = 'x; a16 = 'x; b16 = 'x; cin = 1'bx;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_sum", longint'(sum8), 64'h4A);
      check_eq("hold_cout", longint'(cout8), 64'h0);
      check_eq("hold_out_valid", longint'(vld8), 64'h0);
    end

    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "pre_rst");
    check_eq("pre_rst_out_valid", longint'(vld8), 64'h1);
    rst = 1'b1; in_valid = 1'b1; a8 = 8'h12; b8 = 8'h34; cin = 1'b1;
    tick();
    check_eq("mid_rst_sum", longint'(sum8), 64'h0);
    check_eq("mid_rst_cout", longint'(cout8), 64'h0);
    check_eq("mid_rst_out_valid", longint'(vld8), 64'h0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check_eq("post_rst_out_valid", longint'(vld8), 64'h0);

    for (int i = 0; i < 1000; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      in_valid = ($urandom_range(0, 9) < 8);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      cin = 1'($urandom);
      rand_aux();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
